// File: rtl/ram_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_writer_pkg
// Brief    : Shared state encoding and default geometry for the RAM loader.
// Revision : 1.0 - initial release
// ============================================================================
package ram_writer_pkg;

    localparam int c_N_DEFAULT     = 8;
    localparam int c_DEPTH_DEFAULT = 8;
    localparam int c_AW_DEFAULT    = 3;

    // 2'd3 is unused; the FSM recovers from it to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_writer_if
// Brief    : valid/ready write stream from a data source into the RAM loader.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_writer_if #(
    parameter int N = ram_writer_pkg::c_N_DEFAULT
);
    logic         wr_valid;
    logic [N-1:0] wr_data;
    logic         wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/ram_sp_core.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_core
// Brief    : DEPTH x N RAM, one write port, registered read-before-write read.
// Revision : 1.0 - initial release
// ============================================================================
module ram_sp_core #(
    parameter int N     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [N-1:0]  wdata,
    input  wire logic [AW-1:0] raddr,
    output logic      [N-1:0]  rdata
);

    logic [N-1:0] r_mem [DEPTH];

    // Storage is deliberately unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_writer.sv
`default_nettype none
// ============================================================================
// Module   : ram_writer
// Brief    : Fills a DEPTH x N RAM from a valid/ready stream starting at
//            address 0, and exposes a registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module ram_writer
    import ram_writer_pkg::*;
#(
    parameter int N     = c_N_DEFAULT,
    parameter int DEPTH = c_DEPTH_DEFAULT,
    parameter int AW    = c_AW_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          start,
    ram_writer_if.slave        wr,
    input  wire logic [AW-1:0] rd_addr,
    output logic      [N-1:0]  rd_data,
    output logic      [AW:0]   count,
    output logic               done
);

    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_FULL = (AW + 1)'(DEPTH);

    state_t        r_state;
    logic [AW-1:0] r_wptr;
    logic [AW:0]   r_count;
    logic          r_done;
    logic          w_ready;
    logic          w_xfer;

    assign w_ready     = (r_state == S_LOAD);
    assign wr.wr_ready = w_ready;
    // A start pulse wins over a same-cycle transfer, so the word is dropped.
    assign w_xfer      = wr.wr_valid & w_ready & ~start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (start) begin
            r_state <= S_LOAD;
            r_wptr  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_LOAD: begin
                    if (w_xfer) begin
                        r_wptr <= r_wptr + 1'b1;
                        if (r_count != c_FULL) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (r_wptr == c_LAST) begin
                            r_state <= S_FULL;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_FULL: ;
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign count = r_count;
    assign done  = r_done;

    ram_sp_core #(
        .N     (N),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_xfer),
        .waddr (r_wptr),
        .wdata (wr.wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_ram_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_writer
// Brief    : Directed table plus hand sequences for the RAM loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_writer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic [3:0] count;
    logic       done;

    int n_pass = 0;
    int n_tot  = 0;

    ram_writer_if #(.N(8)) wif ();

    ram_writer #(.N(8), .DEPTH(8), .AW(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .wr      (wif),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .count   (count),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       st;
        logic       v;
        logic [7:0] d;
        logic [2:0] ra;
        logic       e_rdy;
        logic [3:0] e_cnt;
        logic       e_done;
        logic       chk_rd;
        logic [7:0] e_rd;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Apply inputs, take one rising edge, settle 1 time unit past it.
    task automatic step(input logic st, input logic v, input logic [7:0] d, input logic [2:0] ra);
        start        = st;
        wif.wr_valid = v;
        wif.wr_data  = d;
        rd_addr      = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string nm, input logic rdy, input logic [3:0] cnt, input logic dn);
        chk({nm, ".ready"}, {7'd0, wif.wr_ready}, {7'd0, rdy});
        chk({nm, ".count"}, {4'd0, count}, {4'd0, cnt});
        chk({nm, ".done"},  {7'd0, done}, {7'd0, dn});
    endtask

    task automatic readchk(input string nm, input logic [2:0] a, input logic [7:0] exp);
        step(1'b0, 1'b0, 8'h00, a);
        chk(nm, rd_data, exp);
    endtask

    initial begin
        start = 1'b0; wif.wr_valid = 1'b0; wif.wr_data = 8'h00; rd_addr = 3'd0;
        rst_n = 1'b0;
        #2;
        status("reset", 1'b0, 4'd0, 1'b0);
        chk("reset.rd_data", rd_data, 8'h00);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Writes offered in IDLE are ignored.
        step(1'b0, 1'b1, 8'h99, 3'd0);
        status("idle_valid0", 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b1, 8'h98, 3'd0);
        status("idle_valid1", 1'b0, 4'd0, 1'b0);

        // Tests 1 and 2: full load, FULL-state ignore, restart with gaps.
        tbl[0] = '{1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 8'h00};
        for (int k = 1; k <= 8; k++)
            tbl[k] = '{1'b0, 1'b1, 8'(8'h0F + k), 3'd0, (k < 8), 4'(k), (k == 8), 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 3'd3, 1'b0, 4'd8, 1'b1, 1'b1, 8'h13};
        tbl[10] = '{1'b0, 1'b1, 8'hEE, 3'd0, 1'b0, 4'd8, 1'b1, 1'b1, 8'h10};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 4'd8, 1'b1, 1'b1, 8'h10};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 4'd0, 1'b0, 1'b1, 8'h10};
        tbl[13] = '{1'b0, 1'b1, 8'h20, 3'd3, 1'b1, 4'd1, 1'b0, 1'b1, 8'h13};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 4'd1, 1'b0, 1'b1, 8'h20};
        tbl[15] = '{1'b0, 1'b1, 8'h21, 3'd0, 1'b1, 4'd2, 1'b0, 1'b1, 8'h20};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 3'd1, 1'b1, 4'd2, 1'b0, 1'b1, 8'h21};
        tbl[17] = '{1'b0, 1'b1, 8'h22, 3'd2, 1'b1, 4'd3, 1'b0, 1'b1, 8'h12};
        tbl[18] = '{1'b0, 1'b0, 8'h00, 3'd2, 1'b1, 4'd3, 1'b0, 1'b1, 8'h22};
        tbl[19] = '{1'b0, 1'b0, 8'h00, 3'd4, 1'b1, 4'd3, 1'b0, 1'b1, 8'h14};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].st, tbl[i].v, tbl[i].d, tbl[i].ra);
            status($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_cnt, tbl[i].e_done);
            if (tbl[i].chk_rd) chk($sformatf("vec%0d.rd_data", i), rd_data, tbl[i].e_rd);
        end

        // Finish the current load (addrs 3..7), then reload from FULL.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 3'd0);
        status("fill_rest", 1'b0, 4'd8, 1'b1);
        step(1'b1, 1'b0, 8'h00, 3'd0);
        status("reload_start", 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'(8'hF0 + i), 3'd0);
            status($sformatf("reload%0d", i), (i < 7), 4'(i + 1), (i == 7));
        end
        for (int a = 0; a < 8; a++)
            readchk($sformatf("reload_rb%0d", a), 3'(a), 8'(8'hF0 + a));

        // Test 3: restart after 5 words, with a word offered alongside start.
        step(1'b1, 1'b0, 8'h00, 3'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 3'd0);
        status("restart_5", 1'b1, 4'd5, 1'b0);
        step(1'b1, 1'b1, 8'hBB, 3'd0);
        status("restart_pulse", 1'b1, 4'd0, 1'b0);
        step(1'b0, 1'b1, 8'h50, 3'd0);
        status("restart_w0", 1'b1, 4'd1, 1'b0);
        readchk("restart_rb0", 3'd0, 8'h50);
        readchk("restart_rb1", 3'd1, 8'h41);
        readchk("restart_rb4", 3'd4, 8'h44);
        for (int a = 5; a < 8; a++)
            readchk($sformatf("restart_rb%0d", a), 3'(a), 8'(8'hF0 + a));

        // Test 5: same-edge read and write to address 2.
        step(1'b1, 1'b0, 8'h00, 3'd0);
        step(1'b0, 1'b1, 8'hA0, 3'd0);
        step(1'b0, 1'b1, 8'hA1, 3'd0);
        step(1'b0, 1'b1, 8'h55, 3'd0);
        step(1'b1, 1'b0, 8'h00, 3'd0);
        step(1'b0, 1'b1, 8'hA0, 3'd0);
        step(1'b0, 1'b1, 8'hA1, 3'd0);
        step(1'b0, 1'b1, 8'hAA, 3'd2);
        chk("collide_old", rd_data, 8'h55);
        step(1'b0, 1'b0, 8'h00, 3'd2);
        chk("collide_new", rd_data, 8'hAA);

        // Test 4: asynchronous reset part way through a load.
        step(1'b1, 1'b0, 8'h00, 3'd3);
        step(1'b0, 1'b1, 8'hC0, 3'd3);
        step(1'b0, 1'b1, 8'hC1, 3'd3);
        step(1'b0, 1'b1, 8'hC2, 3'd3);
        status("pre_rst", 1'b1, 4'd3, 1'b0);
        chk("pre_rst.rd_data", rd_data, 8'h43);
        wif.wr_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        status("async_rst", 1'b0, 4'd0, 1'b0);
        chk("async_rst.rd_data", rd_data, 8'h00);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        status("post_rst", 1'b0, 4'd0, 1'b0);
        readchk("post_rst_rb0", 3'd0, 8'hC0);
        readchk("post_rst_rb1", 3'd1, 8'hC1);
        readchk("post_rst_rb2", 3'd2, 8'hC2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
